// File: rtl/tmr_pkg.sv
// tmr_pkg: shared types, default parameters and helper functions for the
// TMR vote monitor.
//   tmr_state_e          health state encoding (OK / DEGRADED / FATAL)
//   TMR_CNT_W_DEF        default width of the per-lane total error counter
//   TMR_FAIL_THRESH_DEF  default consecutive-disagreement failure threshold
//   TMR_CONSEC_W         width of the consecutive counter (covers 1..255)
//   maj3()               2-of-3 majority
//   thresh_hit()         one more disagreement will reach the threshold
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_DEGRADED = 2'd1,
    ST_FATAL    = 2'd2
  } tmr_state_e;

  localparam int TMR_CNT_W_DEF       = 8;
  localparam int TMR_FAIL_THRESH_DEF = 4;
  localparam int TMR_CONSEC_W        = 8;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // True when the count sits one below the threshold, so the disagreement
  // being processed now is the one that retires the lane.
  function automatic logic thresh_hit(input logic [TMR_CONSEC_W-1:0] consec,
                                      input int unsigned thresh);
    return (consec == TMR_CONSEC_W'(thresh - 32'd1));
  endfunction

endpackage

// File: rtl/tmr_vote_monitor_if.sv
// tmr_vote_monitor_if: sample input and status output bundle of the TMR
// vote monitor.
//   valid_in, r0, r1, r2   redundant sample and its qualifier
//   clr                    synchronous status clear
//   vote_valid, vote       voted result and its single-cycle qualifier
//   mismatch, lane_err     disagreement pulses for the reported sample
//   err_cnt0..2            saturating per-lane disagreement totals
//   lane_failed            sticky per-lane failure flags
//   state                  health state
// master = sample producer / status consumer, slave = the monitor.
// CNT_W must match the CNT_W of the monitor connected to it.
interface tmr_vote_monitor_if #(
  parameter int CNT_W = tmr_pkg::TMR_CNT_W_DEF
) ();
  import tmr_pkg::*;

  logic             valid_in;
  logic             r0;
  logic             r1;
  logic             r2;
  logic             clr;
  logic             vote_valid;
  logic             vote;
  logic             mismatch;
  logic [2:0]       lane_err;
  logic [CNT_W-1:0] err_cnt0;
  logic [CNT_W-1:0] err_cnt1;
  logic [CNT_W-1:0] err_cnt2;
  logic [2:0]       lane_failed;
  tmr_state_e       state;

  modport master (
    output valid_in, r0, r1, r2, clr,
    input  vote_valid, vote, mismatch, lane_err,
    input  err_cnt0, err_cnt1, err_cnt2, lane_failed, state
  );

  modport slave (
    input  valid_in, r0, r1, r2, clr,
    output vote_valid, vote, mismatch, lane_err,
    output err_cnt0, err_cnt1, err_cnt2, lane_failed, state
  );

endinterface

// File: rtl/tmr_lane_tracker.sv
// tmr_lane_tracker: disagreement bookkeeping for one redundant lane.
//   clk, rst, clr   clock, synchronous reset and synchronous clear
//   sample_en       a sample is being processed this cycle
//   disagree        this lane disagreed with the reference for the sample
//   freeze          ignore the sample (lane retired or fault unattributable)
//   consec_cnt      current run of consecutive disagreements
//   err_cnt         saturating total of disagreements
//   failed          sticky: the run reached FAIL_THRESH
module tmr_lane_tracker import tmr_pkg::*; #(
  parameter int CNT_W       = TMR_CNT_W_DEF,
  parameter int FAIL_THRESH = TMR_FAIL_THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    sample_en,
  input  logic                    disagree,
  input  logic                    freeze,
  output logic [TMR_CONSEC_W-1:0] consec_cnt,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    failed
);

  logic [TMR_CONSEC_W-1:0] consec_r;
  logic [CNT_W-1:0]        err_r;
  logic                    failed_r;
  logic                    upd_s;
  logic                    sat_s;

  // Qualify the update and detect total-counter saturation.
  always_comb begin
    upd_s = sample_en & ~freeze;
    sat_s = (err_r == {CNT_W{1'b1}});
  end

  // Counter and sticky-flag state; failure sets in the same update that
  // counts the threshold-reaching disagreement.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      consec_r <= '0;
      err_r    <= '0;
      failed_r <= 1'b0;
    end else if (upd_s && disagree) begin
      consec_r <= consec_r + TMR_CONSEC_W'(1'b1);
      if (!sat_s) begin
        err_r <= err_r + CNT_W'(1'b1);
      end else begin
        err_r <= err_r;
      end
      if (thresh_hit(consec_r, FAIL_THRESH)) begin
        failed_r <= 1'b1;
      end else begin
        failed_r <= failed_r;
      end
    end else if (upd_s) begin
      consec_r <= '0;
      err_r    <= err_r;
      failed_r <= failed_r;
    end else begin
      consec_r <= consec_r;
      err_r    <= err_r;
      failed_r <= failed_r;
    end
  end

  assign consec_cnt = consec_r;
  assign err_cnt    = err_r;
  assign failed     = failed_r;

endmodule

// File: rtl/tmr_vote_monitor.sv
// tmr_vote_monitor: registers triple-redundant result samples, majority-votes
// them, tracks per-lane disagreement and reports system health.
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   tmr_vote_monitor_if.slave: sample in, clr, vote/status out
// Pipeline: stage 1 captures the sample, stage 2 votes and updates all
// counters, flags and the health state; every output is registered.
module tmr_vote_monitor import tmr_pkg::*; #(
  parameter int CNT_W       = TMR_CNT_W_DEF,
  parameter int FAIL_THRESH = TMR_FAIL_THRESH_DEF
) (
  input logic               clk,
  input logic               rst,
  tmr_vote_monitor_if.slave bus
);

  // Stage 1
  logic       s1_valid_r;
  logic [2:0] s1_lanes_r;

  // Voter
  logic       maj_s;
  logic [2:0] lane_diff_s;
  logic       pair_a_s;
  logic       pair_b_s;
  logic       pair_ok_s;
  logic       pair_agree_s;

  // Lane trackers
  logic [2:0]              disagree_s;
  logic [2:0]              freeze_s;
  logic [2:0]              fail_now_s;
  logic [2:0]              lane_failed_s;
  logic [TMR_CONSEC_W-1:0] consec_s [3];
  logic [CNT_W-1:0]        err_cnt_s [3];

  // FSM and output registers
  tmr_state_e state_r;
  tmr_state_e state_nxt_s;
  logic       vote_valid_r;
  logic       vote_r;
  logic       mismatch_r;
  logic [2:0] lane_err_r;
  logic       vote_valid_nxt_s;
  logic       vote_nxt_s;
  logic       mismatch_nxt_s;
  logic [2:0] lane_err_nxt_s;

  // Stage-1 capture; a sample arriving alongside rst/clr is dropped.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      s1_valid_r <= 1'b0;
      s1_lanes_r <= 3'b000;
    end else begin
      s1_valid_r <= bus.valid_in;
      s1_lanes_r <= {bus.r2, bus.r1, bus.r0};
    end
  end

  // 3-way majority and per-lane difference against it.
  always_comb begin
    maj_s       = maj3(s1_lanes_r[0], s1_lanes_r[1], s1_lanes_r[2]);
    lane_diff_s = s1_lanes_r ^ {3{maj_s}};
  end

  // Select the two surviving lanes in degraded mode; any failure pattern
  // other than exactly one retired lane is treated as a non-agreeing pair.
  always_comb begin
    pair_a_s  = 1'b0;
    pair_b_s  = 1'b0;
    pair_ok_s = 1'b0;
    case (lane_failed_s)
      3'b001: begin
        pair_a_s  = s1_lanes_r[1];
        pair_b_s  = s1_lanes_r[2];
        pair_ok_s = 1'b1;
      end
      3'b010: begin
        pair_a_s  = s1_lanes_r[0];
        pair_b_s  = s1_lanes_r[2];
        pair_ok_s = 1'b1;
      end
      3'b100: begin
        pair_a_s  = s1_lanes_r[0];
        pair_b_s  = s1_lanes_r[1];
        pair_ok_s = 1'b1;
      end
      default: begin
        pair_a_s  = 1'b0;
        pair_b_s  = 1'b0;
        pair_ok_s = 1'b0;
      end
    endcase
    pair_agree_s = pair_ok_s & (pair_a_s == pair_b_s);
  end

  // Tracker controls: only OK mode attributes disagreement to a lane; in
  // degraded mode an agreeing pair resets the survivors' runs, a split pair
  // is unattributable so every tracker holds.
  always_comb begin
    disagree_s = 3'b000;
    freeze_s   = 3'b111;
    case (state_r)
      ST_OK: begin
        disagree_s = lane_diff_s;
        freeze_s   = lane_failed_s;
      end
      ST_DEGRADED: begin
        disagree_s = 3'b000;
        if (pair_agree_s) begin
          freeze_s = lane_failed_s;
        end else begin
          freeze_s = 3'b111;
        end
      end
      default: begin
        disagree_s = 3'b000;
        freeze_s   = 3'b111;
      end
    endcase
  end

  for (genvar i = 0; i < 3; i++) begin : g_lane
    tmr_lane_tracker #(
      .CNT_W       (CNT_W),
      .FAIL_THRESH (FAIL_THRESH)
    ) u_trk (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.clr),
      .sample_en  (s1_valid_r),
      .disagree   (disagree_s[i]),
      .freeze     (freeze_s[i]),
      .consec_cnt (consec_s[i]),
      .err_cnt    (err_cnt_s[i]),
      .failed     (lane_failed_s[i])
    );
  end

  // Lanes whose sticky failure flag sets on this edge.
  always_comb begin
    fail_now_s = 3'b000;
    for (int i = 0; i < 3; i++) begin
      fail_now_s[i] = s1_valid_r & ~freeze_s[i] & disagree_s[i] &
                      thresh_hit(consec_s[i], FAIL_THRESH);
    end
  end

  // Health state register.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      state_r <= ST_OK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Health next-state; the unused encoding falls into FATAL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_OK: begin
        if (s1_valid_r && (fail_now_s != 3'b000)) begin
          state_nxt_s = ST_DEGRADED;
        end else begin
          state_nxt_s = ST_OK;
        end
      end
      ST_DEGRADED: begin
        if (s1_valid_r && !pair_agree_s) begin
          state_nxt_s = ST_FATAL;
        end else begin
          state_nxt_s = ST_DEGRADED;
        end
      end
      ST_FATAL: begin
        state_nxt_s = ST_FATAL;
      end
      default: begin
        state_nxt_s = ST_FATAL;
      end
    endcase
  end

  // Output decode for the sample in stage 2; vote holds when not reported.
  always_comb begin
    vote_valid_nxt_s = 1'b0;
    vote_nxt_s       = vote_r;
    mismatch_nxt_s   = 1'b0;
    lane_err_nxt_s   = 3'b000;
    case (state_r)
      ST_OK: begin
        if (s1_valid_r) begin
          vote_valid_nxt_s = 1'b1;
          vote_nxt_s       = maj_s;
          lane_err_nxt_s   = lane_diff_s;
          mismatch_nxt_s   = |lane_diff_s;
        end else begin
          vote_valid_nxt_s = 1'b0;
        end
      end
      ST_DEGRADED: begin
        if (s1_valid_r && pair_agree_s) begin
          vote_valid_nxt_s = 1'b1;
          vote_nxt_s       = pair_a_s;
        end else if (s1_valid_r) begin
          mismatch_nxt_s = 1'b1;
        end else begin
          vote_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        vote_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered vote and pulse outputs.
  always_ff @(posedge clk) begin
    if (rst || bus.clr) begin
      vote_valid_r <= 1'b0;
      vote_r       <= 1'b0;
      mismatch_r   <= 1'b0;
      lane_err_r   <= 3'b000;
    end else begin
      vote_valid_r <= vote_valid_nxt_s;
      vote_r       <= vote_nxt_s;
      mismatch_r   <= mismatch_nxt_s;
      lane_err_r   <= lane_err_nxt_s;
    end
  end

  assign bus.vote_valid  = vote_valid_r;
  assign bus.vote        = vote_r;
  assign bus.mismatch    = mismatch_r;
  assign bus.lane_err    = lane_err_r;
  assign bus.err_cnt0    = err_cnt_s[0];
  assign bus.err_cnt1    = err_cnt_s[1];
  assign bus.err_cnt2    = err_cnt_s[2];
  assign bus.lane_failed = lane_failed_s;
  assign bus.state       = state_r;

endmodule
